dmem_backing_store: RTL

- Multi-cycle, line-granular data memory behind the data cache controller.
- Accepts one 256-bit line read or write per request, waits a fixed, parameterised latency, then returns a single-cycle `ack_o` pulse with read data.
- Sits directly downstream of the cache controller's memory-side port (`mem_*`), which it feeds with `data_o` and `ack_o`.

---
 rtl/dmem_backing_store.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_backing_store.sv
// dmem_backing_store
//
// Line-granular (256-bit) data memory behind the data cache controller. Each
// request is accepted in IDLE, waits LATENCY cycles in WAIT, and completes with a
// single-cycle ack_o pulse in ACK. Read data is registered into data_o at completion
// and held until the next read completes.
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   Adds err_o and flags requests whose address lies beyond the array. Flagged
//   writes are dropped and flagged reads return zero. Without it, high address
//   bits are ignored and the address aliases modulo the memory size.
//
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - asynchronous active-high reset
//   enable_i  - request valid, held by requester until ack_o
//   write_i   - 1 = line write, 0 = line read (sampled at acceptance)
//   addr_i    - byte address; line index = addr_i[DEPTH_LOG2+4:5]
//   data_i    - write line (sampled at acceptance)
//   ack_o     - one-cycle completion pulse
//   data_o    - read line, valid in the ack_o cycle of a read
//   err_o     - out-of-range flag in the ack_o cycle (DMEM_BOUNDS_CHECK_EN only)

module dmem_backing_store #(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    output logic         err_o
`endif
);

    localparam int unsigned Lines   = 1 << DEPTH_LOG2;
    localparam logic [7:0]  LoadVal = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } state_e;

    // Not reset: contents survive reset and are preloaded externally.
    logic [255:0] memory [0:Lines-1];

    state_e                r_state;
    logic [7:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_write;
    logic [255:0]          r_wdata;
    logic                  r_oob;
    logic                  r_ack;
    logic                  r_err;
    logic [255:0]          r_data;

    logic                  w_oob;
    logic                  w_done;
    logic                  w_unused_addr;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign w_oob         = |addr_i[31:DEPTH_LOG2+5];
    assign w_unused_addr = ^addr_i[4:0];
    assign err_o         = r_err;
`else
    assign w_oob         = 1'b0;
    assign w_unused_addr = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};
`endif

    // Final WAIT edge: the access is performed here and ack_o is registered.
    assign w_done = (r_state == StWait) && (r_cnt == 8'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_oob   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (enable_i) begin
                        r_idx   <= addr_i[DEPTH_LOG2+4:5];
                        r_write <= write_i;
                        r_wdata <= data_i;
                        r_oob   <= w_oob;
                        r_cnt   <= LoadVal;
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= StAck;
                        r_ack   <= 1'b1;
                        r_err   <= r_oob;
                        if (!r_write) begin
                            r_data <= r_oob ? '0 : memory[r_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                StAck: begin
                    // enable_i deliberately ignored here; a held request is
                    // picked up again from IDLE on the next edge.
                    r_state <= StIdle;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    // Reset forces r_state to IDLE asynchronously, so an interrupted write
    // never reaches w_done and the array is left untouched.
    always_ff @(posedge clk_i) begin
        if (w_done && r_write && !r_oob) begin
            memory[r_idx] <= r_wdata;
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_data;

endmodule
